// File: rtl/img_pkg.sv
// Shared types and constants for the image write path.
package img_pkg;

  localparam int DATA_WIDTH = 32;

  // AXI-style write response code for a clean completion
  localparam logic [1:0] BRESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_e;

endpackage

// File: rtl/proc_wr_buffer_sync_fifo.sv
// Synchronous FIFO with zero read latency: rdata_o always shows the head entry.
// A push is refused when full, even if a pop happens in the same cycle.
module sync_fifo #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CW-1:0]         count_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage array; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally (DEPTH is a power of two); count separates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/proc_wr_buffer.sv
// Output stage after the processing stage: buffers words in a FIFO and
// drains them to a master write port as fixed-length bursts, flushing a
// partial tail burst at end of frame and pulsing frame_done when complete.
module proc_wr_buffer
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = img_pkg::DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int BURST_LEN  = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     mstr_data_cmplt,
  input  logic [ADDR_WIDTH-1:0]    cfg_base_addr,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     bresp_err,
  output logic                     frame_done,
  output logic [ADDR_WIDTH-1:0]    m_awaddr,
  output logic [7:0]               m_awlen,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [DATA_WIDTH-1:0]    m_wdata,
  output logic                     m_wvalid,
  output logic                     m_wlast,
  input  logic                     m_wready,
  input  logic                     m_bvalid,
  input  logic [1:0]               m_bresp,
  output logic                     m_bready
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int LW  = $clog2(BURST_LEN) + 1;
  localparam int BPW = DATA_WIDTH / 8;

  wr_state_e             state_q;
  logic [LW-1:0]         len_q, beat_q;
  logic [ADDR_WIDTH-1:0] addr_ptr_q, awaddr_q, cur_addr;
  logic [7:0]            awlen_q;
  logic                  awvalid_q, base_vld_q, flush_pend_q;
  logic                  overflow_q, bresp_err_q, frame_done_q;

  logic                  f_full, f_empty, pop;
  logic [CW-1:0]         f_count;
  logic [DATA_WIDTH-1:0] f_rdata;
  logic                  start_full, start_tail, in_data;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr),
    .pop_i   (pop),
    .wdata_i (data_in),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count),
    .rdata_o (f_rdata)
  );

  assign in_data    = (state_q == DATA);
  assign pop        = in_data && !f_empty && m_wready;

  assign start_full = (f_count >= CW'(BURST_LEN));
  assign start_tail = flush_pend_q && (f_count != '0);

  // Until the first burst of a frame completes, the write pointer is the
  // live cfg_base_addr; this stands in for loading the base on reset and
  // on frame_done without an asynchronous load of a non-constant value.
  assign cur_addr   = base_vld_q ? addr_ptr_q : cfg_base_addr;

  assign fifo_empty = f_empty;
  assign fifo_count = f_count;
  assign overflow   = overflow_q;
  assign bresp_err  = bresp_err_q;
  assign frame_done = frame_done_q;
  assign m_awaddr   = awaddr_q;
  assign m_awlen    = awlen_q;
  assign m_awvalid  = awvalid_q;
  assign m_wvalid   = in_data && !f_empty;
  assign m_wlast    = in_data && (beat_q == len_q - LW'(1));
  assign m_wdata    = in_data ? f_rdata : '0;
  assign m_bready   = (state_q == RESP);

  // Burst FSM with burst bookkeeping, frame flush tracking and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      beat_q       <= '0;
      addr_ptr_q   <= '0;
      base_vld_q   <= 1'b0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      awvalid_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      bresp_err_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (wr && f_full) overflow_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start_full) begin
            len_q     <= LW'(BURST_LEN);
            awlen_q   <= 8'(BURST_LEN - 1);
            awaddr_q  <= cur_addr;
            awvalid_q <= 1'b1;
            state_q   <= ADDR;
          end else if (start_tail) begin
            // Tail is shorter than a full burst, so it fits in len_q.
            len_q     <= f_count[LW-1:0];
            awlen_q   <= 8'(f_count - CW'(1));
            awaddr_q  <= cur_addr;
            awvalid_q <= 1'b1;
            state_q   <= ADDR;
          end else if (flush_pend_q && !wr) begin
            // f_count is zero here: the frame is fully written.
            frame_done_q <= 1'b1;
            flush_pend_q <= 1'b0;
            base_vld_q   <= 1'b0;
          end
        end
        ADDR: begin
          if (m_awready) begin
            awvalid_q <= 1'b0;
            beat_q    <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (pop) begin
            beat_q <= beat_q + LW'(1);
            if (m_wlast) state_q <= RESP;
          end
        end
        RESP: begin
          if (m_bvalid) begin
            addr_ptr_q <= awaddr_q + ADDR_WIDTH'(len_q) * ADDR_WIDTH'(BPW);
            base_vld_q <= 1'b1;
            if (m_bresp != BRESP_OKAY) bresp_err_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A completion pulse always wins over the clear so a new frame's
      // end marker is never lost, even when it arrives mid-burst.
      if (mstr_data_cmplt) flush_pend_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_proc_wr_buffer.sv
// Bench for proc_wr_buffer: table-driven frames plus hand-written overflow
// and mid-burst reset sequences; a scoreboard checks address and data beats.
module tb_proc_wr_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] data_in = '0;
  logic        mstr_data_cmplt = 1'b0;
  logic [31:0] cfg_base_addr = 32'h1000;
  logic        fifo_empty;
  logic [4:0]  fifo_count;
  logic        overflow, bresp_err, frame_done;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic        m_wvalid, m_wlast;
  logic        m_wready = 1'b0;
  logic        m_bvalid = 1'b0;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_bready;

  always #5 clk = ~clk;

  proc_wr_buffer dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in),
    .mstr_data_cmplt(mstr_data_cmplt), .cfg_base_addr(cfg_base_addr),
    .fifo_empty(fifo_empty), .fifo_count(fifo_count), .overflow(overflow),
    .bresp_err(bresp_err), .frame_done(frame_done),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  aw_t         exp_aw[$];
  logic [31:0] exp_data[$];
  int          wlen_q[$];

  int     resp_cnt = 0, fd_cnt = 0, wbeats = 0;
  longint cyc = 0, last_resp_cyc = 0;
  int     aw_dly = 0, resp_base = 0;
  bit     wtog = 1'b0, berr = 1'b0;

  // Slave responder: programmable awready delay, optional wready toggling,
  // bvalid always high, optional error code on the first response of a frame.
  int aw_wait = 0;
  always @(posedge clk) begin
    #1;
    if (!m_awvalid) begin
      aw_wait   = 0;
      m_awready = (aw_dly == 0);
    end else begin
      if (aw_wait >= aw_dly) m_awready = 1'b1;
      aw_wait++;
    end
    m_wready = wtog ? ~m_wready : 1'b1;
    m_bvalid = 1'b1;
    m_bresp  = (berr && resp_cnt == resp_base) ? 2'b10 : 2'b00;
  end

  // Monitor: scoreboard compare on handshakes, payload stability while stalled.
  logic        prev_aws = 1'b0, prev_ws = 1'b0;
  logic [31:0] p_awaddr = '0, p_wdata = '0;
  logic [7:0]  p_awlen = '0;
  int          wbeat = 0, cur_len = 1;
  aw_t         mon_e;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_aws = 1'b0;
      prev_ws  = 1'b0;
      wbeat    = 0;
      wlen_q.delete();
    end else begin
      if (prev_aws) chk("aw_hold", {m_awvalid, m_awaddr, m_awlen}, {1'b1, p_awaddr, p_awlen});
      if (prev_ws)  chk("w_hold", {m_wvalid, m_wdata}, {1'b1, p_wdata});
      if (m_awvalid && m_awready) begin
        if (exp_aw.size() == 0) chk("aw_extra", exp_aw.size(), 1);
        else begin
          mon_e = exp_aw.pop_front();
          chk("awaddr", m_awaddr, mon_e.addr);
          chk("awlen", m_awlen, mon_e.len);
          wlen_q.push_back(int'(mon_e.len) + 1);
        end
      end
      if (m_wvalid && m_wready) begin
        wbeats++;
        if (wbeat == 0) begin
          if (wlen_q.size() == 0) begin
            chk("w_before_aw", wlen_q.size(), 1);
            cur_len = 1;
          end else cur_len = wlen_q.pop_front();
        end
        if (exp_data.size() == 0) chk("w_extra", exp_data.size(), 1);
        else chk("wdata", m_wdata, exp_data.pop_front());
        chk("wlast", m_wlast, (wbeat == cur_len - 1));
        wbeat = (wbeat == cur_len - 1) ? 0 : wbeat + 1;
      end
      if (m_bvalid && m_bready) begin
        resp_cnt++;
        last_resp_cyc = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        chk("fd_gap", ((cyc - last_resp_cyc) >= 2), 1);
      end
      prev_aws = m_awvalid && !m_awready;
      p_awaddr = m_awaddr;
      p_awlen  = m_awlen;
      prev_ws  = m_wvalid && !m_wready;
      p_wdata  = m_wdata;
    end
  end

  // Expected bursts of a frame of n words ending with a completion pulse.
  task automatic build_aw(input logic [31:0] base, input int n);
    aw_t t;
    logic [31:0] a;
    a = base;
    for (int b = 0; b < n / 8; b++) begin
      t.addr = a; t.len = 8'd7;
      exp_aw.push_back(t);
      a += 32;
    end
    if (n % 8 != 0) begin
      t.addr = a; t.len = 8'(n % 8 - 1);
      exp_aw.push_back(t);
    end
  endtask

  // Back-to-back pushes; only the first store_n words are expected downstream.
  task automatic push_words(input int n, input logic [31:0] seed, input int store_n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr      = 1'b1;
      data_in = seed + 32'(i);
      if (i < store_n) exp_data.push_back(seed + 32'(i));
    end
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic cmplt_pulse();
    @(posedge clk); #1; mstr_data_cmplt = 1'b1;
    @(posedge clk); #1; mstr_data_cmplt = 1'b0;
  endtask

  task automatic wait_done(input int fd0);
    int k;
    k = 0;
    while (fd_cnt == fd0 && k < 3000) begin
      @(posedge clk); #3;
      k++;
    end
    if (fd_cnt == fd0) chk("frame_done_wait", fd_cnt - fd0, 1);
    repeat (3) @(posedge clk);
    #3;
  endtask

  task automatic end_checks(input int fd0, input int r0, input int nb, input bit eb, input bit eo);
    chk("frame_done_cnt", fd_cnt - fd0, 1);
    chk("bursts", resp_cnt - r0, nb);
    chk("aw_left", exp_aw.size(), 0);
    chk("data_left", exp_data.size(), 0);
    chk("bresp_err", bresp_err, eb);
    chk("overflow", overflow, eo);
    chk("fifo_empty", fifo_empty, 1);
  endtask

  typedef struct {
    int          n;
    logic [31:0] base;
    int          aw_dly;
    bit          wtog;
    bit          berr;
    int          exp_bursts;
    bit          exp_berr;
  } vec_t;

  vec_t vt[4];

  initial begin
    int fd0, r0, w0, k;

    vt[0] = '{16, 32'h1000, 0, 1'b0, 1'b0, 2, 1'b0};
    vt[1] = '{11, 32'h1000, 0, 1'b0, 1'b0, 2, 1'b0};
    vt[2] = '{16, 32'h1800, 3, 1'b1, 1'b0, 2, 1'b0};
    vt[3] = '{16, 32'h2000, 0, 1'b0, 1'b1, 2, 1'b1};

    // reset state
    #2;
    chk("rst_ctrl", {m_awvalid, m_wvalid, m_wlast, m_bready, frame_done, overflow, bresp_err, m_awlen}, 0);
    chk("rst_data", {m_awaddr, m_wdata}, 0);
    chk("rst_fifo", {fifo_empty, fifo_count}, {1'b1, 5'd0});
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      cfg_base_addr = vt[i].base;
      aw_dly    = vt[i].aw_dly;
      wtog      = vt[i].wtog;
      berr      = vt[i].berr;
      resp_base = resp_cnt;
      r0        = resp_cnt;
      fd0       = fd_cnt;
      build_aw(vt[i].base, vt[i].n);
      push_words(vt[i].n, 32'hC0DE_0000 + 32'(i) * 32'h100, vt[i].n);
      cmplt_pulse();
      wait_done(fd0);
      end_checks(fd0, r0, vt[i].exp_bursts, vt[i].exp_berr, 1'b0);
    end
    berr = 1'b0;
    wtog = 1'b0;

    // overflow: address phase held off so the FIFO fills; 17th word dropped
    cfg_base_addr = 32'h4000;
    aw_dly = 100000;
    r0 = resp_cnt; fd0 = fd_cnt;
    build_aw(32'h4000, 16);
    push_words(17, 32'hBEEF_0000, 16);
    @(posedge clk); #3;
    chk("ovf_count", fifo_count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_aw_stall", {m_awvalid, m_awaddr}, {1'b1, 32'h4000});
    aw_dly = 0;
    cmplt_pulse();
    wait_done(fd0);
    end_checks(fd0, r0, 2, 1'b1, 1'b1);

    // reset during the second burst's data phase
    cfg_base_addr = 32'h3000;
    build_aw(32'h3000, 16);
    w0 = wbeats;
    push_words(16, 32'h5A5A_0000, 16);
    k = 0;
    while (wbeats - w0 < 12 && k < 2000) begin
      @(posedge clk); #2;
      k++;
    end
    chk("beats_before_rst", wbeats - w0, 12);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {m_awvalid, m_wvalid, m_wlast, m_bready, frame_done, overflow, bresp_err, m_awlen}, 0);
    chk("mid_rst_data", {m_awaddr, m_wdata}, 0);
    chk("mid_rst_fifo", {fifo_empty, fifo_count}, {1'b1, 5'd0});
    exp_aw.delete();
    exp_data.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    r0 = resp_cnt; fd0 = fd_cnt;
    build_aw(32'h3000, 8);
    push_words(8, 32'h7700_0000, 8);
    cmplt_pulse();
    wait_done(fd0);
    end_checks(fd0, r0, 1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
